// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter (FIFO + 8N1 serialiser + status + drain IRQ).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_port #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 115_200,
  parameter int unsigned DEPTH   = 8,
  parameter logic [7:0]  DATA_ID = 8'h40,
  parameter logic [7:0]  STAT_ID = 8'h41,
  parameter logic [7:0]  CTRL_ID = 8'h42
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] RD_DATA,
  output logic       RD_HIT,
  output logic       TX,
  output logic       IRQ
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W = $clog2(DIV);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              irq_q, irq_d;
  logic              irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        mem_q [DEPTH];

  logic data_wr_s, ctrl_wr_s, empty_s, full_s, pop_s, push_s, tick_s, busy_s;

  assign data_wr_s = IO_STRB && (PORT_ID == DATA_ID);
  assign ctrl_wr_s = IO_STRB && (PORT_ID == CTRL_ID);
  assign empty_s   = (count_q == CNT_W'(0));
  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign busy_s    = (state_q != S_IDLE);
  assign tick_s    = busy_s && (baud_q == BAUD_W'(DIV - 1));
  // The shifter only reloads from IDLE, so in-frame writes can never disturb TX.
  assign pop_s     = (state_q == S_IDLE) && !empty_s;
  // A full FIFO still accepts a byte when the head is being popped in the same cycle.
  assign push_s    = data_wr_s && (!full_s || pop_s);

  assign RD_HIT  = (PORT_ID == STAT_ID);
  assign RD_DATA = {2'b00, PAR_EN, ovf_q, irq_en_q, busy_s, full_s, empty_s};
  assign TX      = tx_q;
  assign IRQ     = irq_q;

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) state_d = S_START;
        else          state_d = S_IDLE;
      end
      S_START: begin
        if (tick_s) state_d = S_DATA;
        else        state_d = S_START;
      end
      S_DATA: begin
        if (tick_s && (bit_idx_q == 3'd7)) state_d = PAR_EN ? S_PARITY : S_STOP;
        else                               state_d = S_DATA;
      end
      S_PARITY: begin
        if (tick_s) state_d = S_STOP;
        else        state_d = S_PARITY;
      end
      S_STOP: begin
        if (tick_s) state_d = S_IDLE;
        else        state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: baud/bit counters, shifter, FIFO pointers and control bits
  always_comb begin
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;

    if (!busy_s || tick_s) baud_d = BAUD_W'(0);
    else                   baud_d = baud_q + BAUD_W'(1);

    if (state_q == S_START)                bit_idx_d = 3'd0;
    else if ((state_q == S_DATA) && tick_s) bit_idx_d = bit_idx_q + 3'd1;
    else                                    bit_idx_d = bit_idx_q;

    if (pop_s) begin
      shift_d  = mem_q[rd_ptr_q];
      parity_d = even_parity(mem_q[rd_ptr_q]);
    end else if ((state_q == S_DATA) && tick_s) begin
      shift_d  = {1'b0, shift_q[7:1]};
    end else begin
      shift_d  = shift_q;
    end

    if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else        wr_ptr_d = wr_ptr_q;
    if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else        rd_ptr_d = rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (ctrl_wr_s) irq_en_d = OUT_PORT[0];
    else           irq_en_d = irq_en_q;

    if (data_wr_s && full_s && !pop_s) ovf_d = 1'b1;
    else if (ctrl_wr_s && OUT_PORT[1]) ovf_d = 1'b0;
    else                               ovf_d = ovf_q;
  end

  // FSM output logic, registered so TX and IRQ are glitch-free
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:        tx_d = 1'b0;
      S_DATA:         tx_d = shift_d[0];
      S_PARITY:       tx_d = parity_d;
      S_IDLE, S_STOP: tx_d = 1'b1;
      default:        tx_d = 1'b1;
    endcase
    irq_d = (state_q == S_STOP) && tick_s && empty_s && irq_en_q && !data_wr_s;
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      baud_q    <= BAUD_W'(0);
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      wr_ptr_q  <= PTR_W'(0);
      rd_ptr_q  <= PTR_W'(0);
      count_q   <= CNT_W'(0);
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset is needed
  always_ff @(posedge CLK) begin
    if (push_s) mem_q[wr_ptr_q] <= OUT_PORT;
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port (DIV=4, DEPTH=4): a scoreboard of queued bytes is checked
// sample-by-sample against TX by a line monitor; status, IRQ timing and reset are checked inline.
`timescale 1ns/1ps
module tb_uart_tx_port;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int         NBITS   = 11;
  localparam logic [7:0] PAR_BIT = 8'h20;
`else
  localparam int         NBITS   = 10;
  localparam logic [7:0] PAR_BIT = 8'h00;
`endif
  localparam int         FRAME_LEN = NBITS * DIV;
  localparam logic [7:0] DATA_ID   = 8'h40;
  localparam logic [7:0] STAT_ID   = 8'h41;
  localparam logic [7:0] CTRL_ID   = 8'h42;

  logic       CLK, RESET_N, IO_STRB;
  logic [7:0] PORT_ID, OUT_PORT;
  logic [7:0] RD_DATA;
  logic       RD_HIT, TX, IRQ;

  int         n_cmp, n_bad, cyc;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         irq_cyc_q[$];
  bit         mon_active;

  uart_tx_port #(
    .CLK_HZ(1_000_000), .BAUD(250_000), .DEPTH(4),
    .DATA_ID(DATA_ID), .STAT_ID(STAT_ID), .CTRL_ID(CTRL_ID)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .RD_DATA(RD_DATA), .RD_HIT(RD_HIT), .TX(TX), .IRQ(IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    @(posedge CLK);
    #1;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
  endtask

  task automatic send(input logic [7:0] d);
    exp_q.push_back(d);
    wr(DATA_ID, d);
  endtask

  task automatic read_stat(input string tag, input logic [7:0] exp);
    PORT_ID = STAT_ID;
    #1;
    chk({tag, "_hit"}, int'(RD_HIT), 1);
    chk(tag, int'(RD_DATA), int'(exp));
    PORT_ID = 8'h00;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_active) && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, int'(k < budget), 1);
  endtask

  task automatic wait_start(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (start_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, start_q.size(), n);
  endtask

  function automatic int start_at(input int idx);
    return (idx < start_q.size()) ? start_q[idx] : -1;
  endfunction

  function automatic int last_irq();
    return (irq_cyc_q.size() > 0) ? irq_cyc_q[irq_cyc_q.size()-1] : -1;
  endfunction

  // Line monitor: decode each frame from its start edge and compare every sample
  initial begin : monitor
    logic [7:0]  cur;
    logic [10:0] fb;
    int          phase;
    cyc = 0; mon_active = 1'b0; phase = 0; cur = 8'h00; fb = '1;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RESET_N) begin
        mon_active = 1'b0;
        exp_q.delete();
      end else begin
        if (IRQ === 1'b1) irq_cyc_q.push_back(cyc);
        if (!mon_active && TX === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("tx_idle_level", int'(TX), 1);
          end else begin
            cur = exp_q.pop_front();
            fb  = '1;
            fb[0] = 1'b0;
            for (int i = 0; i < 8; i++) fb[1+i] = cur[i];
            if (NBITS == 11) fb[9] = ^cur;
            mon_active = 1'b1;
            phase = 0;
            start_q.push_back(cyc);
          end
        end
        if (mon_active) begin
          chk($sformatf("frame_%02h_ph%0d", cur, phase), int'(TX), int'(fb[phase/DIV]));
          phase++;
          if (phase == FRAME_LEN) mon_active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s0, s1, w, ns, ni;
    n_cmp = 0; n_bad = 0;
    RESET_N = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_tx", int'(TX), 1);
    chk("rst_irq", int'(IRQ), 0);
    step(3);
    RESET_N = 1'b1;
    step(2);
    read_stat("rst_stat", 8'h01 | PAR_BIT);
    PORT_ID = DATA_ID;
    #1;
    chk("rd_hit_other_id", int'(RD_HIT), 0);
    PORT_ID = 8'h00;

    // Single byte: first START two samples after the write, frame checked by the monitor
    send(8'hA5);
    w = cyc;
    wait_start("t1_start", 1, 20);
    chk("t1_latency", start_at(0), w + 2);
    wait_drain("t1_drain", 100);
    step(2);
    read_stat("t1_stat", 8'h01 | PAR_BIT);

    // Five back-to-back writes fill a 4-deep FIFO without overflow
    ns = start_q.size();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    read_stat("t2_full_busy", 8'h06 | PAR_BIT);
    wait_drain("t2_drain", 600);
    chk("t2_frames", start_q.size(), ns + 5);
    for (int i = 1; i < 5 && (ns + i) < start_q.size(); i++)
      chk($sformatf("t2_gap%0d", i), start_q[ns+i] - start_q[ns+i-1], FRAME_LEN + 1);
    step(2);
    read_stat("t2_no_ovf", 8'h01 | PAR_BIT);

    // Six fast writes: the sixth is dropped and sets OVF until cleared by CTRL bit1
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
    wr(DATA_ID, 8'hEE);
    read_stat("t2_ovf", 8'h16 | PAR_BIT);
    wr(CTRL_ID, 8'h02);
    read_stat("t2_ovf_clr", 8'h06 | PAR_BIT);
    wait_drain("t2_drain2", 600);
    step(2);
    read_stat("t2_idle", 8'h01 | PAR_BIT);

    // IRQ pulse on STOP->IDLE with an empty FIFO
    ni = irq_cyc_q.size();
    wr(CTRL_ID, 8'h01);
    read_stat("t3_irqen", 8'h09 | PAR_BIT);
    ns = start_q.size();
    send(8'h3C);
    wait_start("t3_start", ns + 1, 20);
    s0 = start_at(ns);
    wait_drain("t3_drain", 100);
    step(3);
    chk("t3_irq_count", irq_cyc_q.size(), ni + 1);
    chk("t3_irq_cycle", last_irq(), s0 + FRAME_LEN);

    // A push landing on the STOP->IDLE cycle suppresses the pulse and starts one cycle later
    ns = start_q.size();
    send(8'h5A);
    wait_start("t3b_start", ns + 1, 20);
    s0 = start_at(ns);
    while (cyc < s0 + FRAME_LEN - 2) step(1);
    send(8'h96);
    wait_start("t3b_start2", ns + 2, 100);
    s1 = start_at(ns + 1);
    chk("t3_b2b_gap", s1 - s0, FRAME_LEN + 1);
    wait_drain("t3b_drain", 200);
    step(3);
    chk("t3_irq_suppr_count", irq_cyc_q.size(), ni + 2);
    chk("t3_irq_cycle2", last_irq(), s1 + FRAME_LEN);

    // Clearing IRQ_EN mid-frame masks the pulse and leaves the frame intact
    send(8'h81);
    step(10);
    wr(CTRL_ID, 8'h00);
    wait_drain("t3c_drain", 100);
    step(3);
    chk("t3_masked_count", irq_cyc_q.size(), ni + 2);

    // Reset mid-DATA: TX returns high asynchronously, FIFO and frame discarded
    ni = irq_cyc_q.size();
    ns = start_q.size();
    send(8'hFF);
    send(8'h42);
    wait_start("t5_start", ns + 1, 20);
    s0 = start_at(ns);
    while (cyc < s0 + 10) step(1);
    #2 RESET_N = 1'b0;
    #1;
    chk("t5_tx_async", int'(TX), 1);
    chk("t5_irq", int'(IRQ), 0);
    step(3);
    RESET_N = 1'b1;
    step(2);
    read_stat("t5_stat", 8'h01 | PAR_BIT);
    step(60);
    chk("t5_tx_idle", int'(TX), 1);
    chk("t5_no_restart", start_q.size(), ns + 1);
    chk("t5_no_irq", irq_cyc_q.size(), ni);

`ifdef UART_TX_PARITY_EN
    // Even parity: 8'h07 carries parity 1, 8'h03 parity 0; 44-cycle frames
    ns = start_q.size();
    send(8'h07);
    send(8'h03);
    wait_drain("t6_drain", 300);
    chk("t6_frames", start_q.size(), ns + 2);
    chk("t6_gap", start_at(ns + 1) - start_at(ns), 45);
`endif

    step(5);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
